// File: rtl/sm_mul_seq_pkg.sv
// Shared definitions for the schoolMIPS iterative multiply sequencer:
// FSM state codes and a helper for the step-counter width.
package sm_mul_seq_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } msState_t;

    // Counter must hold WIDTH/STEP_BITS, hence the +1.
    function automatic int cntWidth(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/sm_mul_step.sv
// One shift-add step: adds mcand * digit to the accumulator, modulo 2^WIDTH.
// The digit is STEP_BITS wide, so each set bit contributes a shifted multiplicand.
module sm_mul_step #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic [WIDTH-1:0]     acc,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [STEP_BITS-1:0] digit,
    output logic [WIDTH-1:0]     accNext
);

    always_comb begin
        accNext = acc;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (digit[i]) accNext = accNext + (mcand << i);
        end
    end

endmodule

// File: rtl/sm_mul_seq.sv
// Iterative shift-add multiplier for the schoolMIPS MUL instruction.
// Stalls the core while running and pulses done for a one-cycle write-back.
module sm_mul_seq
    import sm_mul_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int STEPS = WIDTH / STEP_BITS;
    localparam int CW    = cntWidth(STEPS);

    msState_t         state, stateNext;
    logic [WIDTH-1:0] mcand, mplier, acc, accNext, mplierNext;
    logic [CW-1:0]    cnt;
    logic             accept, zeroB, lastStep;

    assign accept     = (state == MS_IDLE) && start && !abort;
    assign zeroB      = FAST_ZERO && (srcB == '0);
    assign mplierNext = mplier >> STEP_BITS;
    // Finish on the final digit, or early once no multiplier bits remain.
    assign lastStep   = (cnt == CW'(1)) || (FAST_ZERO && (mplierNext == '0));

    sm_mul_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) uStep (
        .acc     (acc),
        .mcand   (mcand),
        .digit   (mplier[STEP_BITS-1:0]),
        .accNext (accNext)
    );

    // State register; busy/done are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MS_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            busy  <= (stateNext != MS_IDLE);
            done  <= (stateNext == MS_DONE);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            MS_IDLE: if (accept) stateNext = zeroB ? MS_DONE : MS_RUN;
            MS_RUN: begin
                if (abort)         stateNext = MS_IDLE;
                else if (lastStep) stateNext = MS_DONE;
            end
            MS_DONE: stateNext = MS_IDLE;
            default: stateNext = MS_IDLE;
        endcase
    end

    // Released in DONE so write-back and PC advance happen together.
    always_comb begin
        stall = accept || (state == MS_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                MS_IDLE: if (accept) begin
                    mcand  <= srcA;
                    mplier <= srcB;
                    acc    <= '0;
                    cnt    <= CW'(STEPS);
                    if (zeroB) result <= '0;
                end
                MS_RUN: if (!abort) begin
                    acc    <= accNext;
                    mcand  <= mcand << STEP_BITS;
                    mplier <= mplierNext;
                    cnt    <= cnt - CW'(1);
                    if (lastStep) result <= accNext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mul_seq.sv
// Scoreboard bench for sm_mul_seq: three configurations (step 1 fixed latency,
// step 4 early-exit, step 1 early-exit) checked against a plain-arithmetic model.
module tb_sm_mul_seq;

    typedef struct {
        int          inst;
        logic [31:0] res;
        int          t;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  startV = '0;
    logic [2:0]  abortV = '0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic [2:0]  stallV, busyV, doneV;
    logic [31:0] res0, res1, res2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   stallCnt = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm_mul_seq #(.WIDTH(32), .STEP_BITS(1), .FAST_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(startV[0]), .abort(abortV[0]),
        .srcA(srcA), .srcB(srcB), .stall(stallV[0]), .busy(busyV[0]),
        .done(doneV[0]), .result(res0));

    sm_mul_seq #(.WIDTH(32), .STEP_BITS(4), .FAST_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(startV[1]), .abort(abortV[1]),
        .srcA(srcA), .srcB(srcB), .stall(stallV[1]), .busy(busyV[1]),
        .done(doneV[1]), .result(res1));

    sm_mul_seq #(.WIDTH(32), .STEP_BITS(1), .FAST_ZERO(1'b1)) dut2 (
        .clk(clk), .rst(rst), .start(startV[2]), .abort(abortV[2]),
        .srcA(srcA), .srcB(srcB), .stall(stallV[2]), .busy(busyV[2]),
        .done(doneV[2]), .result(res2));

    function automatic int sbOf(input int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic bit fzOf(input int k);
        return (k != 0);
    endfunction

    // Cycles from start acceptance to done.
    function automatic int latOf(input int k, input logic [31:0] b);
        int sb, msb;
        sb  = sbOf(k);
        msb = -1;
        if (!fzOf(k)) return 32 / sb + 1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + sb) / sb + 1;
    endfunction

    function automatic logic [31:0] resOf(input int k);
        case (k)
            0:       return res0;
            1:       return res1;
            default: return res2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: count stall cycles and score every done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (stallV != 3'b000) stallCnt++;
            if (doneV != 3'b000) begin
                if (expQ.size() == 0) begin
                    chk("unexpected done", {61'd0, doneV}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("done instance", {61'd0, doneV}, 64'd1 << e.inst);
                    chk("result", {32'd0, resOf(e.inst)}, {32'd0, e.res});
                    chk("latency", cyc - e.t, e.lat);
                    chk("stall cycles", stallCnt, e.lat);
                    chk("busy in done", {63'd0, busyV[e.inst]}, 64'd1);
                end
                stallCnt = 0;
            end
        end
    end

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        srcA = a;
        srcB = b;
        startV[k] = 1'b1;
        expQ.push_back('{inst: k, res: a * b, t: cyc, lat: latOf(k, b)});
        @(posedge clk); #1;
        startV[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (expQ.size() != 0) begin
            chk("drain timeout", expQ.size(), 0);
            expQ.delete();
        end
        chk("idle after done", {61'd0, busyV}, 64'd0);
    endtask

    // Start, then at the 5th RUN cycle either abort or reset instance 0.
    task automatic interrupt(input bit useRst);
        @(posedge clk); #1;
        srcA = 32'd9;
        srcB = 32'd11;
        startV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (useRst) rst = 1'b1; else abortV[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        abortV[0] = 1'b0;
        chk(useRst ? "busy after rst" : "busy after abort", {63'd0, busyV[0]}, 64'd0);
        chk(useRst ? "stall after rst" : "stall after abort", {63'd0, stallV[0]}, 64'd0);
        chk(useRst ? "result after rst" : "result kept after abort", {32'd0, res0},
            useRst ? 64'd0 : 64'd42);
        repeat (3) @(posedge clk);
        #1;
        stallCnt = 0;
    endtask

    initial begin : stim
        logic [31:0] a, b;
        int t1, lat1, n;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {61'd0, busyV}, 64'd0);
        chk("reset done", {61'd0, doneV}, 64'd0);
        chk("reset result0", {32'd0, res0}, 64'd0);
        chk("reset result1", {32'd0, res1}, 64'd0);
        rst = 1'b0;
        #1;
        chk("reset stall", {61'd0, stallV}, 64'd0);
        stallCnt = 0;

        // Fixed latency: 33 cycles to done.
        issue(0, 32'd7, 32'd6);
        drain();
        interrupt(1'b0);
        chk("no done after abort", expQ.size(), 0);

        // Early exit on zero and on a short multiplier.
        issue(2, 32'h1234, 32'h0);
        drain();
        issue(2, 32'h1234, 32'h6);
        drain();

        // Wrap-around products.
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(1, 32'h8000_0000, 32'h2);
        drain();
        issue(2, 32'h8000_0000, 32'h2);
        drain();

        // start held through DONE: one pulse, then the next MUL in the following IDLE.
        @(posedge clk); #1;
        srcA = 32'h1234;
        srcB = 32'h6;
        startV[2] = 1'b1;
        t1   = cyc;
        lat1 = latOf(2, 32'h6);
        expQ.push_back('{inst: 2, res: 32'h1234 * 32'h6, t: t1, lat: lat1});
        expQ.push_back('{inst: 2, res: 32'd5 * 32'h11, t: t1 + lat1 + 1, lat: latOf(2, 32'h11)});
        @(posedge clk); #1;
        srcA = 32'd5;
        srcB = 32'h11;
        n = 0;
        while (cyc < t1 + lat1 + 1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        startV[2] = 1'b0;
        drain();

        // abort in IDLE blocks acceptance and masks stall.
        @(posedge clk); #1;
        srcA = 32'd3;
        srcB = 32'd3;
        startV[1] = 1'b1;
        abortV[1] = 1'b1;
        #1;
        chk("stall masked by abort", {63'd0, stallV[1]}, 64'd0);
        @(posedge clk); #1;
        startV[1] = 1'b0;
        abortV[1] = 1'b0;
        chk("abort blocks start", {63'd0, busyV[1]}, 64'd0);

        // Reset mid-RUN clears result.
        issue(0, 32'd7, 32'd6);
        drain();
        interrupt(1'b1);

        // Random operands, biased toward zero and short multipliers.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            issue(1, a, b);
            drain();
        end
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : $urandom_range(0, 1023);
            issue(2, a, b);
            drain();
        end
        for (int i = 0; i < 10; i++) begin
            issue(0, $urandom, $urandom);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
